// File: rtl/regfile_sb.sv
// Integer register file with a per-register pending-result scoreboard.
// Reads are combinational with writeback bypass; busy state and busy_cnt are registered.
module regfile_sb #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NREG       = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned INIT_IDX_A = 10,
    parameter int unsigned INIT_VAL_A = 15,
    parameter int unsigned INIT_IDX_B = 21,
    parameter int unsigned INIT_VAL_B = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic [AW:0]     busy_cnt
);

    localparam int unsigned IDXW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned CW   = AW + 1;

    // Address names a real, writable register (x0 and out-of-range are not).
    function automatic logic isValid(input logic [AW-1:0] addr);
        return (addr != '0) && (32'(addr) < NREG);
    endfunction

    function automatic logic [XLEN-1:0] resetVal(input int unsigned idx);
        logic [XLEN-1:0] val;
        val = '0;
        if (idx != 0 && idx == INIT_IDX_A) val = XLEN'(INIT_VAL_A);
        if (idx != 0 && idx == INIT_IDX_B) val = XLEN'(INIT_VAL_B);
        return val;
    endfunction

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busyBits;
    logic [NREG-1:0] busyNext;

    logic [IDXW-1:0] rs1Idx, rs2Idx, wrIdx, issIdx;
    logic            rs1Valid, rs2Valid, issValid;
    logic            wrEff, issAccept;
    logic            setBit, clearBit;

    assign rs1Idx   = IDXW'(rs1_addr);
    assign rs2Idx   = IDXW'(rs2_addr);
    assign wrIdx    = IDXW'(wr_addr);
    assign issIdx   = IDXW'(iss_rd);
    assign rs1Valid = isValid(rs1_addr);
    assign rs2Valid = isValid(rs2_addr);
    assign issValid = isValid(iss_rd);
    assign wrEff    = wr_en && isValid(wr_addr);

    // Read ports: bypass wins over stored data; a same-cycle writeback hides the hazard.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (wrEff && wr_addr == rs1_addr) rs1_data = wr_data;
        else if (rs1Valid)                rs1_data = regs[rs1Idx];
        if (wrEff && wr_addr == rs2_addr) rs2_data = wr_data;
        else if (rs2Valid)                rs2_data = regs[rs2Idx];
        rs1_busy = rs1Valid && busyBits[rs1Idx] && !(wr_en && wr_addr == rs1_addr);
        rs2_busy = rs2Valid && busyBits[rs2Idx] && !(wr_en && wr_addr == rs2_addr);
    end

    // Issue acceptance and next busy vector; an accepted issue overrides a same-edge clear.
    always_comb begin
        iss_ready = !issValid || !busyBits[issIdx] || (wr_en && wr_addr == iss_rd);
        issAccept = iss_en && iss_ready && issValid;
        setBit    = issAccept && !busyBits[issIdx];
        clearBit  = wrEff && busyBits[wrIdx] && !(issAccept && iss_rd == wr_addr);
        busyNext  = busyBits;
        if (wrEff)     busyNext[wrIdx]  = 1'b0;
        if (issAccept) busyNext[issIdx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[IDXW'(i)] <= resetVal(i);
            end
        end else if (wrEff) begin
            regs[wrIdx] <= wr_data;
        end
    end

    // busy_cnt tracks the popcount of busyBits incrementally.
    always_ff @(posedge clk) begin
        if (reset) begin
            busyBits <= '0;
            busy_cnt <= '0;
        end else begin
            busyBits <= busyNext;
            if (setBit && !clearBit)      busy_cnt <= busy_cnt + CW'(1);
            else if (clearBit && !setBit) busy_cnt <= busy_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based model; a second instance covers NREG=20, XLEN=32.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic        wr_en, iss_en;
    logic [63:0] wr_data;
    logic [63:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy, iss_ready;
    logic [5:0]  busy_cnt;

    logic        p_reset;
    logic [4:0]  p_rs1_addr, p_rs2_addr, p_wr_addr, p_iss_rd;
    logic        p_wr_en, p_iss_en;
    logic [31:0] p_wr_data;
    logic [31:0] p_rs1_data, p_rs2_data;
    logic        p_rs1_busy, p_rs2_busy, p_iss_ready;
    logic [5:0]  p_busy_cnt;

    int nChecks = 0;
    int nPass   = 0;

    logic [63:0] mreg  [32];
    bit          mbusy [32];
    int          mcnt;

    regfile_sb dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(32), .NREG(20), .AW(5)) pdut (
        .clk(clk), .reset(p_reset),
        .rs1_addr(p_rs1_addr), .rs2_addr(p_rs2_addr),
        .rs1_data(p_rs1_data), .rs2_data(p_rs2_data),
        .rs1_busy(p_rs1_busy), .rs2_busy(p_rs2_busy),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
        .iss_en(p_iss_en), .iss_rd(p_iss_rd), .iss_ready(p_iss_ready),
        .busy_cnt(p_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model for the default instance (NREG=32, so every non-zero address is valid).
    function automatic logic [63:0] expData(input logic [4:0] a);
        if (a == 0) return 64'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic bit expBusy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        return mbusy[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic bit expReady();
        if (iss_rd == 0) return 1'b1;
        return !mbusy[iss_rd] || (wr_en && wr_addr == iss_rd);
    endfunction

    task automatic modelEdge();
        bit acc;
        acc = iss_en && expReady() && iss_rd != 0;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i]  = 64'h0;
                mbusy[i] = 1'b0;
            end
            mreg[10] = 64'd15;
            mreg[21] = 64'd4;
        end else begin
            if (wr_en && wr_addr != 0) begin
                mreg[wr_addr]  = wr_data;
                mbusy[wr_addr] = 1'b0;
            end
            if (acc) mbusy[iss_rd] = 1'b1;
        end
        mcnt = 0;
        for (int i = 0; i < 32; i++) mcnt += int'(mbusy[i]);
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        reset = 0; wr_en = 0; iss_en = 0;
        wr_addr = 0; iss_rd = 0; wr_data = 0;
    endtask

    task automatic test_reset();
        logic [63:0] want;
        reset = 1; wr_en = 1; wr_addr = 10; wr_data = 64'hFF; iss_en = 1; iss_rd = 3;
        tick();
        setIdle();
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            want = (a == 10) ? 64'd15 : (a == 21) ? 64'd4 : 64'd0;
            nChecks++;
            if (rs1_data !== want)
                $display("FAIL reset_data x%0d: got %0h expected %0h", a, rs1_data, want);
            else nPass++;
            nChecks++;
            if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
                $display("FAIL reset_busy x%0d: got %b/%b expected 0/0", a, rs1_busy, rs2_busy);
            else nPass++;
        end
        nChecks++;
        if (busy_cnt !== 6'd0 || iss_ready !== 1'b1)
            $display("FAIL reset_cnt_ready: got cnt=%0d ready=%b expected 0/1", busy_cnt, iss_ready);
        else nPass++;
    endtask

    task automatic test_x0_bypass();
        wr_en = 1; wr_addr = 0; wr_data = 64'hDEAD; rs1_addr = 0;
        #1;
        nChecks++;
        if (rs1_data !== 64'h0) $display("FAIL x0_comb: got %0h expected 0", rs1_data);
        else nPass++;
        tick();
        wr_en = 0;
        #1;
        nChecks++;
        if (rs1_data !== 64'h0) $display("FAIL x0_after: got %0h expected 0", rs1_data);
        else nPass++;
        wr_en = 1; wr_addr = 5; wr_data = 64'h1234; rs1_addr = 5;
        #1;
        nChecks++;
        if (rs1_data !== 64'h1234) $display("FAIL bypass_x5: got %0h expected 1234", rs1_data);
        else nPass++;
        tick();
        wr_en = 0;
        #1;
        nChecks++;
        if (rs1_data !== 64'h1234) $display("FAIL stored_x5: got %0h expected 1234", rs1_data);
        else nPass++;
    endtask

    task automatic test_scoreboard();
        iss_en = 1; iss_rd = 7; rs2_addr = 7;
        #1;
        nChecks++;
        if (iss_ready !== 1'b1) $display("FAIL sb_ready: got %b expected 1", iss_ready);
        else nPass++;
        tick();
        iss_en = 0;
        #1;
        nChecks++;
        if (rs2_busy !== 1'b1 || busy_cnt !== 6'd1)
            $display("FAIL sb_set: got busy=%b cnt=%0d expected 1/1", rs2_busy, busy_cnt);
        else nPass++;
        wr_en = 1; wr_addr = 7; wr_data = 64'h77;
        #1;
        nChecks++;
        if (rs2_busy !== 1'b0) $display("FAIL sb_hide: got %b expected 0", rs2_busy);
        else nPass++;
        tick();
        wr_en = 0;
        #1;
        nChecks++;
        if (rs2_busy !== 1'b0 || busy_cnt !== 6'd0)
            $display("FAIL sb_clear: got busy=%b cnt=%0d expected 0/0", rs2_busy, busy_cnt);
        else nPass++;
    endtask

    task automatic test_waw();
        iss_en = 1; iss_rd = 7; rs2_addr = 7;
        tick();
        #1;
        nChecks++;
        if (iss_ready !== 1'b0) $display("FAIL waw_stall: got ready=%b expected 0", iss_ready);
        else nPass++;
        tick();
        nChecks++;
        if (busy_cnt !== 6'd1 || rs2_busy !== 1'b1)
            $display("FAIL waw_hold: got cnt=%0d busy=%b expected 1/1", busy_cnt, rs2_busy);
        else nPass++;
        wr_en = 1; wr_addr = 7; wr_data = 64'hABCD;
        #1;
        nChecks++;
        if (iss_ready !== 1'b1) $display("FAIL waw_wr_ready: got %b expected 1", iss_ready);
        else nPass++;
        tick();
        wr_en = 0; iss_en = 0;
        #1;
        nChecks++;
        if (rs2_busy !== 1'b1 || busy_cnt !== 6'd1 || rs2_data !== 64'hABCD)
            $display("FAIL waw_win: got busy=%b cnt=%0d data=%0h expected 1/1/abcd",
                     rs2_busy, busy_cnt, rs2_data);
        else nPass++;
        wr_en = 1; wr_addr = 7; wr_data = 64'h1;
        tick();
        wr_en = 0;
        #1;
        nChecks++;
        if (busy_cnt !== 6'd0) $display("FAIL waw_drain: got cnt=%0d expected 0", busy_cnt);
        else nPass++;
    endtask

    task automatic test_reset_mid();
        iss_en = 1; iss_rd = 3;
        tick();
        iss_rd = 4;
        tick();
        iss_en = 0;
        #1;
        nChecks++;
        if (busy_cnt !== 6'd2) $display("FAIL mid_pre: got cnt=%0d expected 2", busy_cnt);
        else nPass++;
        reset = 1; wr_en = 1; wr_addr = 3; wr_data = 64'h99;
        tick();
        setIdle();
        rs1_addr = 3; rs2_addr = 4;
        #1;
        nChecks++;
        if (rs1_data !== 64'h0 || busy_cnt !== 6'd0 || rs2_busy !== 1'b0)
            $display("FAIL mid_reset: got data=%0h cnt=%0d busy4=%b expected 0/0/0",
                     rs1_data, busy_cnt, rs2_busy);
        else nPass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            iss_en   = $urandom_range(0, 1) == 1;
            wr_addr  = 5'($urandom_range(0, 7));
            iss_rd   = 5'($urandom_range(0, 7));
            rs1_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            wr_data  = {$urandom, $urandom};
            #1;
            nChecks++;
            if (rs1_data !== expData(rs1_addr) || rs2_data !== expData(rs2_addr))
                $display("FAIL rnd_data cyc%0d: got %0h/%0h expected %0h/%0h", n,
                         rs1_data, rs2_data, expData(rs1_addr), expData(rs2_addr));
            else nPass++;
            nChecks++;
            if (rs1_busy !== expBusy(rs1_addr) || rs2_busy !== expBusy(rs2_addr))
                $display("FAIL rnd_busy cyc%0d: got %b/%b expected %b/%b", n,
                         rs1_busy, rs2_busy, expBusy(rs1_addr), expBusy(rs2_addr));
            else nPass++;
            nChecks++;
            if (iss_ready !== expReady())
                $display("FAIL rnd_ready cyc%0d: got %b expected %b", n, iss_ready, expReady());
            else nPass++;
            tick();
            nChecks++;
            if (int'(busy_cnt) != mcnt)
                $display("FAIL rnd_cnt cyc%0d: got %0d expected %0d", n, busy_cnt, mcnt);
            else nPass++;
        end
        setIdle();
    endtask

    task automatic test_param();
        p_reset = 1;
        tick();
        p_reset = 0;
        p_rs1_addr = 25; p_rs2_addr = 10;
        #1;
        nChecks++;
        if (p_rs1_data !== 32'h0 || p_rs1_busy !== 1'b0 || p_rs2_data !== 32'd15)
            $display("FAIL par_reset: got x25=%0h busy=%b x10=%0h expected 0/0/f",
                     p_rs1_data, p_rs1_busy, p_rs2_data);
        else nPass++;
        p_wr_en = 1; p_wr_addr = 25; p_wr_data = 32'h5555_AAAA;
        p_iss_en = 1; p_iss_rd = 25;
        #1;
        nChecks++;
        if (p_iss_ready !== 1'b1 || p_rs1_data !== 32'h0)
            $display("FAIL par_oob_comb: got ready=%b data=%0h expected 1/0", p_iss_ready, p_rs1_data);
        else nPass++;
        tick();
        p_wr_en = 0; p_iss_en = 0;
        #1;
        nChecks++;
        if (p_busy_cnt !== 6'd0 || p_rs1_data !== 32'h0 || p_rs1_busy !== 1'b0)
            $display("FAIL par_oob_ignored: got cnt=%0d data=%0h busy=%b expected 0/0/0",
                     p_busy_cnt, p_rs1_data, p_rs1_busy);
        else nPass++;
        p_wr_en = 1; p_wr_addr = 19; p_wr_data = 32'hCAFE_F00D;
        p_iss_en = 1; p_iss_rd = 18;
        tick();
        p_wr_en = 0; p_iss_en = 0;
        p_rs1_addr = 19; p_rs2_addr = 18;
        #1;
        nChecks++;
        if (p_rs1_data !== 32'hCAFE_F00D || p_busy_cnt !== 6'd1 || p_rs2_busy !== 1'b1)
            $display("FAIL par_roundtrip: got data=%0h cnt=%0d busy18=%b expected cafef00d/1/1",
                     p_rs1_data, p_busy_cnt, p_rs2_busy);
        else nPass++;
    endtask

    initial begin
        setIdle();
        reset = 1; rs1_addr = 0; rs2_addr = 0;
        p_reset = 1; p_wr_en = 0; p_iss_en = 0; p_wr_addr = 0; p_iss_rd = 0;
        p_wr_data = 0; p_rs1_addr = 0; p_rs2_addr = 0;
        for (int i = 0; i < 32; i++) begin
            mreg[i] = 64'h0;
            mbusy[i] = 1'b0;
        end
        mcnt = 0;
        #3;
        test_reset();
        test_x0_bypass();
        test_scoreboard();
        test_waw();
        test_reset_mid();
        test_random();
        test_param();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
